// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the configurable UART receiver:
//                parity mode enum, receiver state enum, received-word struct
//                and the expected-parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Widest supported data field; narrower frames leave the top bits at 0.
    localparam int c_MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        PUSH   = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic                       frame_err;
        logic                       parity_err;
        logic [c_MAX_DATA_BITS-1:0] data;
    } rx_word_t;

    // Parity bit a correct transmitter would send for this data word.
    // Unused upper data bits are zero, so they do not disturb the XOR.
    function automatic logic parity_calc(input logic [c_MAX_DATA_BITS-1:0] data,
                                         input parity_e                    mode);
        case (mode)
            ODD:     return ~(^data);
            EVEN:    return ^data;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through FIFO for received words. The head
//                entry is presented combinationally on o_rdata (zero when
//                empty). Pointers carry an extra wrap bit for full/empty.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push, i_wdata - write strobe and data (ignored when full
//                                  unless a pop happens in the same cycle)
//                i_pop           - consume head entry (ignored when empty)
//                o_rdata         - head entry
//                o_full, o_empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A simultaneous pop frees the head slot, so a push while full still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Configurable UART receiver (5-9 data bits, none/odd/even
//                parity, 1 or 2 stop bits) with input synchroniser, false
//                start rejection, parity/framing flags, break detection and a
//                FWFT receive FIFO read through a valid/ready handshake.
//  Ports       : i_Clock, i_Reset    - clock, synchronous active-high reset
//                i_Rx_Serial         - asynchronous serial line (idles high)
//                i_Rx_Ready          - pops head word together with o_Rx_DV
//                i_Clear_Overrun     - clears the sticky overrun flag
//                o_Rx_DV, o_Rx_Byte  - head word valid / data
//                o_Parity_Err        - head word parity error
//                o_Frame_Err         - head word framing error
//                o_Break             - one-cycle break pulse
//                o_Overrun           - sticky dropped-word flag
//                o_Rx_Active         - frame reception in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    input  logic                 i_Clear_Overrun,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun,
    output logic                 o_Rx_Active
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam parity_e            c_PMODE     = (PARITY == 1) ? ODD :
                                                 (PARITY == 2) ? EVEN : NONE;
    localparam int                 c_WORD_W    = $bits(rx_word_t);

    logic [1:0]                 r_sync;
    logic                       w_rx_s;
    rx_state_e                  r_state;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [3:0]                 r_bit_idx;
    logic                       r_stop_idx;
    logic [c_MAX_DATA_BITS-1:0] r_data;
    logic                       r_pbit;
    logic                       r_perr;
    logic                       r_ferr;
    logic                       r_overrun;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;
    logic                       w_full;
    logic                       w_empty;
    rx_word_t                   w_wword;
    logic [c_WORD_W-1:0]        w_head_bits;
    rx_word_t                   w_head;
    logic                       w_unused_hi;

    // Two-flop synchroniser; reset to the idle line level.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_Rx_Serial};
        end
    end
    assign w_rx_s = r_sync[1];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_pbit     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The detect cycle counts as cycle 0, so the counter
                    // starts at 1 and the start sample lands H cycles later.
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
                START: begin
                    if (r_cnt == c_HALF) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;   // glitch, not a real start bit
                        end else begin
                            r_state   <= DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_data    <= '0;
                            r_pbit    <= 1'b0;
                            r_perr    <= 1'b0;
                            r_ferr    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt             <= '0;
                        r_data[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= (c_PMODE != NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_pbit  <= w_rx_s;
                        r_perr  <= (w_rx_s != parity_calc(r_data, c_PMODE));
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_ferr <= 1'b1;
                        end
                        // Leaving at mid-stop lets the next start bit be
                        // caught in the second half of the stop bit.
                        if (r_stop_idx == c_LAST_STOP) begin
                            r_state <= PUSH;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PUSH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_push  = (r_state == PUSH);
    assign w_wword = '{frame_err: r_ferr, parity_err: r_perr, data: r_data};

    uart_rx_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .i_push  (w_push),
        .i_wdata (w_wword),
        .i_pop   (i_Rx_Ready),
        .o_rdata (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = i_Rx_Ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    // A new overrun takes priority over a clear in the same cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_Clear_Overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_head      = rx_word_t'(w_head_bits);
    assign w_unused_hi = ^w_head.data;

    assign o_Rx_DV      = !w_empty;
    assign o_Rx_Byte    = w_head.data[DATA_BITS-1:0];
    assign o_Parity_Err = w_head.parity_err;
    assign o_Frame_Err  = w_head.frame_err;
    assign o_Overrun    = r_overrun;
    assign o_Rx_Active  = (r_state != IDLE);
    // Break: all-zero data, zero parity bit (if any) and a bad stop bit.
    assign o_Break      = w_push && (r_data == '0) && !r_pbit && r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Scoreboard bench for uart_rx_cfg. dut0 is 8N1, dut1 is
//                7 data bits / even parity / 2 stop bits; both use 20 clocks
//                per bit on a 100 ns clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CPB = 20;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic       clr0 = 1'b0, clr1 = 1'b0;

    logic       dv0, pe0, fe0, brk0, ov0, act0;
    logic [7:0] byte0;
    logic       dv1, pe1, fe1, brk1, ov1, act1;
    logic [6:0] byte1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   dv0_cycles = 0;
    int   brk0_cycles = 0;

    always #50 clk = ~clk;

    uart_rx_cfg #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_dut0 (
        .i_Clock (clk), .i_Reset (rst), .i_Rx_Serial (rx0), .i_Rx_Ready (rdy0),
        .i_Clear_Overrun (clr0), .o_Rx_DV (dv0), .o_Rx_Byte (byte0),
        .o_Parity_Err (pe0), .o_Frame_Err (fe0), .o_Break (brk0),
        .o_Overrun (ov0), .o_Rx_Active (act0)
    );

    uart_rx_cfg #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_dut1 (
        .i_Clock (clk), .i_Reset (rst), .i_Rx_Serial (rx1), .i_Rx_Ready (rdy1),
        .i_Clear_Overrun (clr1), .o_Rx_DV (dv1), .o_Rx_Byte (byte1),
        .o_Parity_Err (pe1), .o_Frame_Err (fe1), .o_Break (brk1),
        .o_Overrun (ov1), .o_Rx_Active (act1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else          rx1 = b;
    endtask

    task automatic expect_word(input int sel, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // uart_tx-style bit model. abort_bit >= 0 stops half way through that
    // bit and leaves the line there; chk_act probes o_Rx_Active of dut0
    // around the middle of the first stop bit.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int pmode, input bit pflip, input int nstop,
                              input int abort_bit, input bit chk_act);
        logic [15:0] frame;
        int          n;
        logic        p;
        frame    = '1;
        n        = 0;
        frame[n] = 1'b0;
        n++;
        for (int i = 0; i < nbits; i++) begin
            frame[n] = data[i];
            n++;
        end
        if (pmode != 0) begin
            p = ^data;
            if (pmode == 1) p = ~p;
            frame[n] = p ^ pflip;
            n++;
        end
        n = n + nstop;
        for (int i = 0; i < n; i++) begin
            set_line(sel, frame[i]);
            if (i == abort_bit) begin
                step(CPB / 2);
                return;
            end
            if (chk_act && i == n - nstop) begin
                step(5);
                check("rx_active early in stop bit", 32'(act0), 32'd1);
                step(12);
                check("rx_active low after mid-stop", 32'(act0), 32'd0);
                step(CPB - 17);
            end else begin
                step(CPB);
            end
        end
    endtask

    task automatic monitor0();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dv0)  dv0_cycles++;
            if (brk0) brk0_cycles++;
            if (!rst && dv0 && rdy0) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut0 unexpected word: got %0h, expected none", byte0);
                end else begin
                    e = q0.pop_front();
                    check("dut0 data", 32'(byte0), 32'(e.data));
                    check("dut0 parity_err", 32'(pe0), 32'(e.perr));
                    check("dut0 frame_err", 32'(fe0), 32'(e.ferr));
                end
            end
        end
    endtask

    task automatic monitor1();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && dv1 && rdy1) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut1 unexpected word: got %0h, expected none", byte1);
                end else begin
                    e = q1.pop_front();
                    check("dut1 data", 32'(byte1), 32'(e.data));
                    check("dut1 parity_err", 32'(pe1), 32'(e.perr));
                    check("dut1 frame_err", 32'(fe1), 32'(e.ferr));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded 20000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        fork
            monitor0();
            monitor1();
        join_none

        // Reset state
        rst = 1'b1;
        step(5);
        check("dut0 outputs in reset", 32'({dv0, pe0, fe0, brk0, ov0, act0, byte0}), 32'd0);
        check("dut1 outputs in reset", 32'({dv1, pe1, fe1, brk1, ov1, act1, byte1}), 32'd0);
        rst = 1'b0;
        step(5);

        // 8N1 0xA5 with consumer always ready
        snap = dv0_cycles;
        expect_word(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, -1, 1'b1);
        step(5);
        check("rx_dv pulse width", 32'(dv0_cycles - snap), 32'd1);

        // 7E2: 0x41 has even weight, so the correct even parity bit is 0
        expect_word(1, 9'h041, 1'b0, 1'b0);
        send_frame(1, 9'h041, 7, 2, 1'b0, 2, -1, 1'b0);
        expect_word(1, 9'h041, 1'b1, 1'b0);
        send_frame(1, 9'h041, 7, 2, 1'b1, 2, -1, 1'b0);
        step(5);

        // Glitch rejection then a good frame
        set_line(0, 1'b0);
        step(5);
        set_line(0, 1'b1);
        step(2 * CPB);
        check("glitch rx_active", 32'(act0), 32'd0);
        check("glitch rx_dv", 32'(dv0), 32'd0);
        expect_word(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, -1, 1'b0);
        step(5);

        // Break: line low 12.5 bit times. First frame is the break word; the
        // receiver then restarts on the still-low line, takes bits 0..1 low
        // and bits 2..7 high after release, giving 0xFC with a good stop bit.
        snap = brk0_cycles;
        expect_word(0, 9'h000, 1'b0, 1'b1);
        expect_word(0, 9'h0FC, 1'b0, 1'b0);
        set_line(0, 1'b0);
        step(12 * CPB + CPB / 2);
        set_line(0, 1'b1);
        step(12 * CPB);
        check("break pulse count", 32'(brk0_cycles - snap), 32'd1);

        // Overrun: depth 4, consumer stalled, five frames
        rdy0 = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) expect_word(0, 9'(b), 1'b0, 1'b0);
            send_frame(0, 9'(b), 8, 0, 1'b0, 1, -1, 1'b0);
            if (b == 4) begin
                check("no overrun while fifo fills", 32'(ov0), 32'd0);
                check("head held while stalled (4)", 32'(byte0), 32'h01);
            end
        end
        check("overrun after 5th frame", 32'(ov0), 32'd1);
        check("head held while stalled (5)", 32'(byte0), 32'h01);
        check("rx_dv with full fifo", 32'(dv0), 32'd1);
        rdy0 = 1'b1;
        step(10);
        check("rx_dv after draining", 32'(dv0), 32'd0);
        check("overrun sticky after drain", 32'(ov0), 32'd1);
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        step(1);
        check("overrun cleared", 32'(ov0), 32'd0);

        // Reset in the middle of the data bits of 0x55
        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 4, 1'b0);
        rst = 1'b1;
        set_line(0, 1'b1);
        step(3);
        check("mid-frame reset rx_active", 32'(act0), 32'd0);
        rst = 1'b0;
        step(2 * CPB);
        check("after reset no word", 32'({dv0, act0, pe0, fe0}), 32'd0);
        expect_word(0, 9'h099, 1'b0, 1'b0);
        send_frame(0, 9'h099, 8, 0, 1'b0, 1, -1, 1'b0);
        step(20);

        check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
        check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
